branch_perf_mon: RTL and testbench

BRANCH_PERF_MON -- requirements
Module: branch_perf_mon

---
 rtl/branch_perf_mon.sv | 151 +++++++++++++++
 tb/tb_branch_perf_mon.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_perf_mon.sv
// ---------------------------------------------------------------------------
// branch_perf_mon
//
// Retirement-side branch performance monitor. Four 32-bit live counters
// (CYC, INSN, CTRL, MIS) track cycles, retired instructions, retired
// control transfers and mispredicted control transfers. A snapshot request
// freezes all four into shadow registers. A small IDLE/SEND FSM then streams
// the shadow words out over a valid/ready port, in index order 0..3.
//
// Optional feature:
//   BRANCH_PERF_SAT_EN  When defined, each live counter saturates at
//                       32'hFFFF_FFFF. When undefined, each counter wraps
//                       to 0.
//
// Ports:
//   i_clk          sole clock, rising edge
//   i_reset        asynchronous active-high reset
//   i_insn_vld     a retired instruction is valid this cycle
//   i_ctrl         retired instruction is a branch/jump
//   i_mispred      retired branch/jump was mispredicted
//   i_pc_debug     PC of the retired instruction
//   i_clear        synchronous zeroing of live counters and o_last_mis_pc
//   i_snap_req     request snapshot and readout
//   i_rd_ready     consumer accepts the current readout word
//   o_rd_valid     readout word valid
//   o_rd_data      readout word (0=CYC, 1=INSN, 2=CTRL, 3=MIS)
//   o_rd_idx       index of the readout word
//   o_busy         readout in progress
//   o_last_mis_pc  PC of the most recent counted mispredict
// ---------------------------------------------------------------------------
module branch_perf_mon (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_insn_vld,
    input  logic        i_ctrl,
    input  logic        i_mispred,
    input  logic [31:0] i_pc_debug,
    input  logic        i_clear,
    input  logic        i_snap_req,
    input  logic        i_rd_ready,
    output logic        o_rd_valid,
    output logic [31:0] o_rd_data,
    output logic [1:0]  o_rd_idx,
    output logic        o_busy,
    output logic [31:0] o_last_mis_pc
);

    typedef enum logic {IDLE, SEND} state_t;

    state_t      state;
    logic [31:0] cyc_cnt;
    logic [31:0] insn_cnt;
    logic [31:0] ctrl_cnt;
    logic [31:0] mis_cnt;
    logic [31:0] shadow [0:3];

    // Qualified events: i_ctrl only counts on a valid instruction, and
    // i_mispred only counts on a valid control transfer.
    logic insn_hit;
    logic ctrl_hit;
    logic mis_hit;

    assign insn_hit = i_insn_vld;
    assign ctrl_hit = i_insn_vld & i_ctrl;
    assign mis_hit  = i_insn_vld & i_ctrl & i_mispred;

    function automatic logic [31:0] bump(input logic [31:0] value);
`ifdef BRANCH_PERF_SAT_EN
        return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
`else
        return value + 32'd1;
`endif
    endfunction

    // Live counters. Clear takes priority over any increment in the same cycle.
    // NOTE: state is written with non-blocking assignments so that every
    // always_ff block samples the pre-edge values. The FSM below relies on
    // this when it snapshots the counters in the same cycle as a clear.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            cyc_cnt       <= '0;
            insn_cnt      <= '0;
            ctrl_cnt      <= '0;
            mis_cnt       <= '0;
            o_last_mis_pc <= '0;
        end else if (i_clear) begin
            cyc_cnt       <= '0;
            insn_cnt      <= '0;
            ctrl_cnt      <= '0;
            mis_cnt       <= '0;
            o_last_mis_pc <= '0;
        end else begin
            cyc_cnt <= bump(cyc_cnt);
            if (insn_hit) insn_cnt <= bump(insn_cnt);
            if (ctrl_hit) ctrl_cnt <= bump(ctrl_cnt);
            if (mis_hit) begin
                mis_cnt       <= bump(mis_cnt);
                o_last_mis_pc <= i_pc_debug;
            end
        end
    end

    // Snapshot/readout FSM. All outputs are registered. The word for index 0
    // is loaded directly from the live counter when the request is taken.
    // Later words are preloaded from the shadow registers on each handshake.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state      <= IDLE;
            o_rd_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_rd_idx   <= '0;
            o_rd_data  <= '0;
            // NOTE: the shadow array is small and a readable reset value is
            // required, so it is reset explicitly. Larger memories would
            // normally be left unreset.
            for (int i = 0; i < 4; i++) shadow[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_snap_req) begin
                        shadow[0]  <= cyc_cnt;
                        shadow[1]  <= insn_cnt;
                        shadow[2]  <= ctrl_cnt;
                        shadow[3]  <= mis_cnt;
                        o_rd_data  <= cyc_cnt;
                        o_rd_idx   <= 2'd0;
                        o_rd_valid <= 1'b1;
                        o_busy     <= 1'b1;
                        state      <= SEND;
                    end
                end
                SEND: begin
                    // i_snap_req is deliberately ignored in this state.
                    if (i_rd_ready) begin
                        if (o_rd_idx == 2'd3) begin
                            o_rd_valid <= 1'b0;
                            o_busy     <= 1'b0;
                            o_rd_idx   <= 2'd0;
                            state      <= IDLE;
                        end else begin
                            o_rd_idx  <= o_rd_idx + 2'd1;
                            o_rd_data <= shadow[o_rd_idx + 2'd1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_perf_mon.sv
// ---------------------------------------------------------------------------
// tb_branch_perf_mon
//
// Directed bench for branch_perf_mon. Inputs are driven on the falling edge
// and outputs are sampled on the falling edge, half a cycle after the rising
// edge that updated them. Expected INSN/CTRL/MIS values are computed by hand.
// CYC is tracked with a cycle count that restarts on reset or clear.
// The saturating build is expected to define BRANCH_PERF_SAT_EN for both
// files.
// ---------------------------------------------------------------------------
module tb_branch_perf_mon;

    logic        i_clk;
    logic        i_reset;
    logic        i_insn_vld;
    logic        i_ctrl;
    logic        i_mispred;
    logic [31:0] i_pc_debug;
    logic        i_clear;
    logic        i_snap_req;
    logic        i_rd_ready;
    logic        o_rd_valid;
    logic [31:0] o_rd_data;
    logic [1:0]  o_rd_idx;
    logic        o_busy;
    logic [31:0] o_last_mis_pc;

    int          tests_run = 0;
    int          tests_failed = 0;
    logic [31:0] cyc_count = 0;

    branch_perf_mon dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_insn_vld   (i_insn_vld),
        .i_ctrl       (i_ctrl),
        .i_mispred    (i_mispred),
        .i_pc_debug   (i_pc_debug),
        .i_clear      (i_clear),
        .i_snap_req   (i_snap_req),
        .i_rd_ready   (i_rd_ready),
        .o_rd_valid   (o_rd_valid),
        .o_rd_data    (o_rd_data),
        .o_rd_idx     (o_rd_idx),
        .o_busy       (o_busy),
        .o_last_mis_pc(o_last_mis_pc)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Advance one clock. The CYC expectation follows the inputs that are
    // present at the rising edge.
    task automatic step();
        if (i_reset || i_clear) cyc_count = 0;
        else cyc_count = cyc_count + 32'd1;
        @(negedge i_clk);
    endtask

    task automatic retire(input logic ctrl, input logic mis, input logic [31:0] pc);
        i_insn_vld = 1'b1;
        i_ctrl     = ctrl;
        i_mispred  = mis;
        i_pc_debug = pc;
        step();
        i_insn_vld = 1'b0;
        i_ctrl     = 1'b0;
        i_mispred  = 1'b0;
        i_pc_debug = '0;
    endtask

    // Request a snapshot and consume all four words. With hold > 0, the
    // consumer stalls for that many cycles on word 0. During the stall,
    // i_snap_req stays high and instructions keep retiring, so the bench can
    // show that a request in SEND is ignored and that the shadow data is
    // unaffected by ongoing counting.
    task automatic snapshot(input string tag, input int hold, input logic clr,
                            input logic [31:0] e_insn, input logic [31:0] e_ctrl,
                            input logic [31:0] e_mis);
        logic [31:0] exp_w [4];
        exp_w[0] = cyc_count;
        exp_w[1] = e_insn;
        exp_w[2] = e_ctrl;
        exp_w[3] = e_mis;
        i_snap_req = 1'b1;
        i_clear    = clr;
        i_rd_ready = (hold == 0);
        step();
        i_clear = 1'b0;
        if (hold == 0) i_snap_req = 1'b0;
        check({tag, " valid0"}, {31'd0, o_rd_valid}, 32'd1);
        check({tag, " busy0"}, {31'd0, o_busy}, 32'd1);
        check({tag, " idx0"}, {30'd0, o_rd_idx}, 32'd0);
        check({tag, " word0"}, o_rd_data, exp_w[0]);
        for (int h = 0; h < hold; h++) begin
            i_insn_vld = 1'b1;
            step();
            check({tag, " hold valid"}, {31'd0, o_rd_valid}, 32'd1);
            check({tag, " hold busy"}, {31'd0, o_busy}, 32'd1);
            check({tag, " hold idx"}, {30'd0, o_rd_idx}, 32'd0);
            check({tag, " hold word0"}, o_rd_data, exp_w[0]);
        end
        i_insn_vld = 1'b0;
        i_snap_req = 1'b0;
        i_rd_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            step();
            check({tag, " valid"}, {31'd0, o_rd_valid}, 32'd1);
            check({tag, " idx"}, {30'd0, o_rd_idx}, i);
            check({tag, " word"}, o_rd_data, exp_w[i]);
        end
        step();
        check({tag, " done valid"}, {31'd0, o_rd_valid}, 32'd0);
        check({tag, " done busy"}, {31'd0, o_busy}, 32'd0);
        i_rd_ready = 1'b0;
    endtask

    initial begin
        i_reset    = 1'b1;
        i_insn_vld = 1'b0;
        i_ctrl     = 1'b0;
        i_mispred  = 1'b0;
        i_pc_debug = '0;
        i_clear    = 1'b0;
        i_snap_req = 1'b0;
        i_rd_ready = 1'b0;
        step();
        step();
        check("rst valid", {31'd0, o_rd_valid}, 32'd0);
        check("rst busy", {31'd0, o_busy}, 32'd0);
        check("rst idx", {30'd0, o_rd_idx}, 32'd0);
        check("rst data", o_rd_data, 32'd0);
        check("rst last_pc", o_last_mis_pc, 32'd0);
        i_reset = 1'b0;

        // 10 instructions: 4 control transfers, one of them mispredicted at 0x40.
        retire(1'b1, 1'b0, 32'h0000_0010);
        retire(1'b0, 1'b0, 32'h0000_0014);
        retire(1'b1, 1'b1, 32'h0000_0040);
        retire(1'b0, 1'b0, 32'h0000_0044);
        retire(1'b1, 1'b0, 32'h0000_0048);
        retire(1'b0, 1'b0, 32'h0000_004C);
        retire(1'b0, 1'b0, 32'h0000_0050);
        retire(1'b1, 1'b0, 32'h0000_0054);
        retire(1'b0, 1'b0, 32'h0000_0058);
        retire(1'b0, 1'b0, 32'h0000_005C);
        check("basic last_pc", o_last_mis_pc, 32'h0000_0040);
        snapshot("basic", 0, 1'b0, 32'd10, 32'd4, 32'd1);

        // Mispredict flag with no control transfer, then with no valid insn.
        retire(1'b0, 1'b1, 32'h0000_0200);
        i_ctrl = 1'b1; i_mispred = 1'b1; i_pc_debug = 32'h0000_0300;
        step();
        i_ctrl = 1'b0; i_mispred = 1'b0; i_pc_debug = '0;
        check("qual last_pc", o_last_mis_pc, 32'h0000_0040);

        // Stalled readout: 5 held cycles during which 5 more instructions retire.
        snapshot("stall", 5, 1'b0, 32'd11, 32'd4, 32'd1);
        snapshot("count_in_send", 0, 1'b0, 32'd16, 32'd4, 32'd1);

        // Clear, 7 instructions, then snapshot and clear in the same cycle.
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        check("clear last_pc", o_last_mis_pc, 32'd0);
        for (int i = 0; i < 7; i++) retire(1'b0, 1'b0, 32'h0000_1000);
        snapshot("snap_clr", 0, 1'b1, 32'd7, 32'd0, 32'd0);
        retire(1'b1, 1'b1, 32'h0000_0080);
        retire(1'b0, 1'b0, 32'h0000_0084);
        retire(1'b0, 1'b0, 32'h0000_0088);
        check("post_clr last_pc", o_last_mis_pc, 32'h0000_0080);
        snapshot("post_clr", 0, 1'b0, 32'd3, 32'd1, 32'd1);

        // Counter limit: INSN forced to all-ones, then two more instructions.
        force dut.insn_cnt = 32'hFFFF_FFFF;
        step();
        release dut.insn_cnt;
        retire(1'b0, 1'b0, 32'h0000_2000);
        retire(1'b0, 1'b0, 32'h0000_2004);
`ifdef BRANCH_PERF_SAT_EN
        snapshot("limit", 0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1);
`else
        snapshot("limit", 0, 1'b0, 32'd1, 32'd1, 32'd1);
`endif

        // Reset in the middle of a readout, while word 2 is presented.
        i_snap_req = 1'b1;
        i_rd_ready = 1'b1;
        step();
        i_snap_req = 1'b0;
        step();
        step();
        check("abort idx2", {30'd0, o_rd_idx}, 32'd2);
        i_reset = 1'b1;
        #1;
        check("abort valid", {31'd0, o_rd_valid}, 32'd0);
        check("abort busy", {31'd0, o_busy}, 32'd0);
        check("abort idx", {30'd0, o_rd_idx}, 32'd0);
        check("abort data", o_rd_data, 32'd0);
        check("abort last_pc", o_last_mis_pc, 32'd0);
        step();
        i_reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_abort valid", {31'd0, o_rd_valid}, 32'd0);
        end
        i_rd_ready = 1'b0;
        snapshot("post_abort", 0, 1'b0, 32'd0, 32'd0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
